// File: rtl/smart_counter_pkg.sv
// Shared types and default timing for the clock/timer digit stages.
// Imported by both the up-counting and down-counting digit modules.
package smart_counter_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUTTON_PRESSED = 2'd1,
        BUTTON_HOLD    = 2'd2
    } btn_state_t;

    localparam int CLK_HZ            = 100000000;
    localparam int DEFAULT_TRIG_MAX  = CLK_HZ;
    localparam int DEFAULT_PRESS_MAX = 3 * CLK_HZ;
    localparam int DEFAULT_HOLD_MAX  = CLK_HZ / 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trigger_prescaler.sv
// Counts enabled trigger pulses modulo MAX.
// done flags the pulse that completes a period.
module trigger_prescaler #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic done
);

    localparam int W = $clog2(MAX) + 1;

    logic [W-1:0] cnt;

    assign done = count_en && (cnt == W'(MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/smart_down_counter.sv
// Countdown digit stage: prescaled tick decrement with borrow output, preset
// load, and button decrement with press-and-hold auto-repeat.
module smart_down_counter
    import smart_counter_pkg::*;
#(
    parameter int OUTPUT_COUNTER_MAX       = 60,
    parameter int COUNTER_TRIGGER_MAX      = DEFAULT_TRIG_MAX,
    parameter int COUNTER_BUTTON_PRESS_MAX = DEFAULT_PRESS_MAX,
    parameter int COUNTER_HOLD_MAX         = DEFAULT_HOLD_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       BTN_pos,
    input  logic       BTN_neg,
    output logic       trigger_out,
    output logic [7:0] output_counter,
    output logic       is_zero,
    output logic [1:0] dbg_state
);

    localparam int BTN_W = $clog2(max_int(COUNTER_BUTTON_PRESS_MAX, COUNTER_HOLD_MAX)) + 1;
    localparam logic [7:0]       VAL_TOP   = 8'(OUTPUT_COUNTER_MAX - 1);
    localparam logic [8:0]       VAL_MOD   = 9'(OUTPUT_COUNTER_MAX);
    localparam logic [BTN_W-1:0] PRESS_TOP = BTN_W'(COUNTER_BUTTON_PRESS_MAX - 1);
    localparam logic [BTN_W-1:0] HOLD_TOP  = BTN_W'(COUNTER_HOLD_MAX - 1);

    btn_state_t       state;
    logic [BTN_W-1:0] btn_cnt;
    logic             tick_en;
    logic             tick_done;
    logic [7:0]       val_dec;
    logic [7:0]       load_clamped;

    // Ticks are only counted while no button activity owns the digit.
    assign tick_en      = (state == IDLE) && enable && trigger;
    assign val_dec      = (output_counter == 8'd0) ? VAL_TOP : output_counter - 8'd1;
    assign load_clamped = ({1'b0, load_value} >= VAL_MOD) ? VAL_TOP : load_value;
    assign is_zero      = (output_counter == 8'd0);
    assign dbg_state    = state;

    trigger_prescaler #(
        .MAX(COUNTER_TRIGGER_MAX)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear   (load),
        .count_en(tick_en),
        .done    (tick_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_counter <= 8'd0;
            trigger_out    <= 1'b0;
            btn_cnt        <= '0;
            state          <= IDLE;
        end else if (load) begin
            output_counter <= load_clamped;
            trigger_out    <= 1'b0;
            btn_cnt        <= '0;
            state          <= IDLE;
        end else begin
            trigger_out <= 1'b0;
            case (state)
                IDLE: begin
                    btn_cnt <= '0;
                    // A completing tick absorbs a coincident button press.
                    if (tick_done) begin
                        output_counter <= val_dec;
                        trigger_out    <= (output_counter == 8'd0);
                    end else if (BTN_pos) begin
                        output_counter <= val_dec;
                    end
                    if (BTN_pos) state <= BUTTON_PRESSED;
                end
                BUTTON_PRESSED: begin
                    if (btn_cnt == PRESS_TOP) output_counter <= val_dec;
                    if (BTN_neg) begin
                        state   <= IDLE;
                        btn_cnt <= '0;
                    end else if (btn_cnt == PRESS_TOP) begin
                        state   <= BUTTON_HOLD;
                        btn_cnt <= '0;
                    end else begin
                        btn_cnt <= btn_cnt + 1'b1;
                    end
                end
                BUTTON_HOLD: begin
                    if (btn_cnt == HOLD_TOP) output_counter <= val_dec;
                    if (BTN_neg) begin
                        state   <= IDLE;
                        btn_cnt <= '0;
                    end else if (btn_cnt == HOLD_TOP) begin
                        btn_cnt <= '0;
                    end else begin
                        btn_cnt <= btn_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    btn_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/smart_down_counter.md
Name: smart_down_counter

Overview:
Countdown counterpart of the clock's up-counting digit stage, used for timer/alarm digits (seconds/minutes/hours).
- A prescaler counts input trigger pulses. Each completed prescale period decrements the value modulo OUTPUT_COUNTER_MAX.
- Wrapping 0 -> MAX-1 emits a one-cycle borrow pulse (trigger_out), which feeds the next-higher stage's trigger.
- Supports synchronous preset load, run enable, and button decrement with press-and-hold auto-repeat.

Parameters:
- OUTPUT_COUNTER_MAX, 60: modulus of the value; legal values are 0..MAX-1, MAX <= 256.
- COUNTER_TRIGGER_MAX, 100000000: trigger pulses per decrement; 1 means every trigger decrements (cascade use).
- COUNTER_BUTTON_PRESS_MAX, 300000000: cycles the button is held before auto-repeat starts.
- COUNTER_HOLD_MAX, 50000000: cycles between auto-repeat decrements.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- trigger, input, 1: one-cycle tick (1 Hz enable or lower-stage borrow).
- enable, input, 1: run; when 0, the prescaler freezes and ticks are ignored.
- load, input, 1: synchronous preset strobe.
- load_value, input, 8: preset value.
- BTN_pos, input, 1: debounced button rising-edge pulse.
- BTN_neg, input, 1: debounced button falling-edge pulse.
- trigger_out, output, 1: borrow pulse, one cycle, registered.
- output_counter, output, 8: current value, registered.
- is_zero, output, 1: combinational, equals (output_counter == 0).

Behaviour:
- Reset (rst low, async): output_counter = 0, trigger_out = 0, prescaler = 0, button counter = 0, state = IDLE.
- All updates happen on posedge clk.
- FSM states:
  - IDLE -> BUTTON_PRESSED on BTN_pos.
  - BUTTON_PRESSED -> IDLE on BTN_neg.
  - BUTTON_PRESSED -> BUTTON_HOLD when the button counter reaches COUNTER_BUTTON_PRESS_MAX-1.
  - BUTTON_HOLD -> IDLE on BTN_neg.
  - Encoding is 2 bits; the unused code recovers to IDLE.
- Load has the highest priority, in any state:
  - output_counter <= load_value, clamped to MAX-1 if load_value >= MAX.
  - Prescaler and button counter are cleared, state <= IDLE, trigger_out <= 0.
- Tick, evaluated only in IDLE with enable = 1 and trigger = 1:
  - If prescaler == COUNTER_TRIGGER_MAX-1: prescaler <= 0 and output_counter is decremented.
  - Otherwise the prescaler increments.
- Tick decrement:
  - output_counter != 0: value - 1, trigger_out stays 0.
  - output_counter == 0: value <= MAX-1 and trigger_out <= 1 for exactly one cycle.
  - Result: trigger_out is asserted in the cycle output_counter first shows MAX-1 (one-cycle latency from the tick).
- Button decrement rules:
  - In IDLE, BTN_pos decrements once.
  - In BUTTON_PRESSED, reaching PRESS_MAX-1 decrements once and clears the counter.
  - In BUTTON_HOLD, reaching HOLD_MAX-1 decrements once, clears the counter and stays in BUTTON_HOLD.
  - Button decrements wrap 0 -> MAX-1 and never assert trigger_out.
- Button counter: increments each cycle in BUTTON_PRESSED/BUTTON_HOLD; cleared in IDLE and on every transition.
- Prescaler is frozen outside IDLE; ticks arriving there are dropped.
- Simultaneous tick completion and BTN_pos in IDLE: only the tick decrement applies (net -1), and the state still moves to BUTTON_PRESSED.
- BTN_neg in the same cycle as a hold-threshold hit: the decrement applies and the state goes to IDLE.
- enable = 0: the prescaler holds its value, and buttons and load still operate.
- Width rules:
  - Prescaler width is $clog2(COUNTER_TRIGGER_MAX)+1; button counter width is $clog2(max(PRESS_MAX, HOLD_MAX))+1.
  - All comparisons use equality with MAX-1, so no overflow is possible.
- Reset asserted mid-hold or mid-prescale: immediate return to reset values; no trigger_out glitch.

Decomposition:
- Package smart_counter_pkg holds:
  - the state enum (IDLE, BUTTON_PRESSED, BUTTON_HOLD) as logic [1:0];
  - default timing constants (CLK_HZ = 100000000, press/hold cycle counts), shared with the up-counting stage.
- One sub-module: trigger_prescaler.
  - Parameter MAX; ports clk, rst, clear, count_en, done.
  - done is the combinational wrap indication.
- FSM, button counter and value register stay in the top module.

Test Plan:
Benches use OUTPUT_COUNTER_MAX=60, COUNTER_TRIGGER_MAX=4, PRESS_MAX=8, HOLD_MAX=3.
1. Reset, load 5, then 20 enabled triggers -> output_counter steps 5,4,3,2,1,0 every 4th trigger; trigger_out stays 0.
2. Load 0, then 4 triggers -> output_counter = 59; trigger_out high exactly one cycle, coincident with 59; is_zero drops.
3. Load 70 -> output_counter = 59; then load 3 mid-prescale (prescaler = 2) -> value 3 and the next decrement requires 4 fresh triggers.
4. Load 10, BTN_pos, hold 20 cycles, then BTN_neg -> values 9, then 8 at cycle 8, then 7 and 6 at +3 and +6 cycles; state returns to IDLE.
5. Value 0, single BTN_pos -> 59 with trigger_out = 0; triggers during BUTTON_PRESSED leave the prescaler unchanged.
6. Assert rst low during BUTTON_HOLD, asynchronously between clock edges -> outputs are 0 immediately; after release, ticks decrement normally from 0 with a borrow.
